// File: rtl/uart_dec_line_reader_pkg.sv
// ============================================================================
//  Module      : line_reader_pkg
//  Description : Shared types and constants for the decimal line reader.
//                Macro LINE_BACKSPACE_EN widens the echo queue to three bytes.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package line_reader_pkg;

    localparam int c_MAX_DIGITS_DEF = 5;
    localparam int c_ACC_W          = 20;

    localparam logic [7:0] c_ASCII_CR  = 8'h0D;
    localparam logic [7:0] c_ASCII_LF  = 8'h0A;
    localparam logic [7:0] c_ASCII_BS  = 8'h08;
    localparam logic [7:0] c_ASCII_DEL = 8'h7F;
    localparam logic [7:0] c_ASCII_SP  = 8'h20;
    localparam logic [7:0] c_ASCII_0   = 8'h30;

`ifdef LINE_BACKSPACE_EN
    localparam int c_ECHO_DEPTH = 3;
`else
    localparam int c_ECHO_DEPTH = 1;
`endif

    // The three echo states live in line_echo_tx; the parent sees them as ST_ECHO.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_ECHO    = 3'd2,
        ST_CONVERT = 3'd3,
        ST_DONE    = 3'd4
    } line_state_t;

    typedef enum logic [1:0] {
        ES_IDLE       = 2'd0,
        ES_REQ        = 2'd1,
        ES_WAIT_START = 2'd2,
        ES_WAIT_END   = 2'd3
    } echo_state_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= c_ASCII_0) && (b <= (c_ASCII_0 + 8'd9));
    endfunction

    // Returns {overflow, value}.
    function automatic logic [16:0] saturate16(input logic [c_ACC_W-1:0] acc);
        if (acc > c_ACC_W'(32'd65535)) begin
            return {1'b1, 16'hFFFF};
        end
        return {1'b0, acc[15:0]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_dec_line_reader_if.sv
// ============================================================================
//  Module      : uart_dec_line_reader_if
//  Description : Handshake bundle between console FSM / uart and line reader.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_dec_line_reader_if;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        tx_busy;
    logic        tx_req;
    logic [7:0]  tx_data;
    logic        busy;
    logic [15:0] value;
    logic        value_valid;
    logic        overflow;
    logic        rx_dropped;

    modport master (
        output start, rx_valid, rx_byte, tx_busy,
        input  tx_req, tx_data, busy, value, value_valid, overflow, rx_dropped
    );

    modport slave (
        input  start, rx_valid, rx_byte, tx_busy,
        output tx_req, tx_data, busy, value, value_valid, overflow, rx_dropped
    );
endinterface

`default_nettype wire

// File: rtl/uart_dec_line_reader_echo_tx.sv
// ============================================================================
//  Module      : line_echo_tx
//  Description : Echo byte queue and transmit handshake against uart tx_busy.
//                Queue depth follows LINE_BACKSPACE_EN (3 bytes, else 1).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module line_echo_tx
    import line_reader_pkg::*;
(
    input  wire logic                      clk,
    input  wire logic                      rst,
    input  wire logic                      load_i,
    input  wire logic [1:0]                load_cnt_i,
    input  wire logic [8*c_ECHO_DEPTH-1:0] load_data_i,
    input  wire logic                      tx_busy_i,
    output logic                           tx_req_o,
    output logic [7:0]                     tx_data_o,
    output logic                           echo_idle_o
);

    echo_state_t state_q, state_d;
    logic        tx_req_q, tx_req_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        w_pop;
    logic [1:0]  w_rem_cnt;
    logic [7:0]  w_rem_head;

    generate
        if (c_ECHO_DEPTH > 1) begin : g_queue
            logic [8*(c_ECHO_DEPTH-1)-1:0] rem_q;
            logic [1:0]                    cnt_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    rem_q <= '0;
                    cnt_q <= '0;
                end else if (load_i && (state_q == ES_IDLE)) begin
                    rem_q <= load_data_i[8*c_ECHO_DEPTH-1:8];
                    cnt_q <= load_cnt_i - 2'd1;
                end else if (w_pop) begin
                    rem_q <= rem_q >> 8;
                    cnt_q <= cnt_q - 2'd1;
                end
            end

            assign w_rem_cnt  = cnt_q;
            assign w_rem_head = rem_q[7:0];
        end else begin : g_single
            logic w_unused_cnt;
            assign w_unused_cnt = ^load_cnt_i;
            assign w_rem_cnt    = 2'd0;
            assign w_rem_head   = 8'h00;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ES_IDLE;
            tx_req_q  <= 1'b0;
            tx_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            tx_req_q  <= tx_req_d;
            tx_data_q <= tx_data_d;
        end
    end

    // echo_idle_o also rises in the final WAIT_END cycle so the parent can
    // resume COLLECT on the same edge this block drops to idle.
    always_comb begin
        state_d     = state_q;
        tx_req_d    = tx_req_q;
        tx_data_d   = tx_data_q;
        w_pop       = 1'b0;
        echo_idle_o = 1'b0;
        case (state_q)
            ES_IDLE: begin
                echo_idle_o = 1'b1;
                if (load_i) begin
                    tx_data_d = load_data_i[7:0];
                    tx_req_d  = 1'b1;
                    state_d   = ES_REQ;
                end
            end
            ES_REQ: begin
                if (!tx_busy_i) begin
                    tx_req_d = 1'b0;
                    state_d  = ES_WAIT_START;
                end
            end
            ES_WAIT_START: begin
                if (tx_busy_i) begin
                    state_d = ES_WAIT_END;
                end
            end
            ES_WAIT_END: begin
                if (!tx_busy_i) begin
                    if (w_rem_cnt != 2'd0) begin
                        w_pop     = 1'b1;
                        tx_data_d = w_rem_head;
                        tx_req_d  = 1'b1;
                        state_d   = ES_REQ;
                    end else begin
                        echo_idle_o = 1'b1;
                        state_d     = ES_IDLE;
                    end
                end
            end
            default: state_d = ES_IDLE;
        endcase
    end

    assign tx_req_o  = tx_req_q;
    assign tx_data_o = tx_data_q;

endmodule

`default_nettype wire

// File: rtl/uart_dec_line_reader.sv
// ============================================================================
//  Module      : uart_dec_line_reader
//  Description : Collects echoed decimal digits up to CR and converts them to a
//                saturated 16-bit value. LINE_BACKSPACE_EN enables BS/DEL edit.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_dec_line_reader
    import line_reader_pkg::*;
#(
    parameter int MAX_DIGITS = c_MAX_DIGITS_DEF
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    uart_dec_line_reader_if.slave     bus
);

    localparam int c_CNT_W = $clog2(MAX_DIGITS + 1);

    line_state_t          state_q, state_d;
    logic [3:0]           digits_q [MAX_DIGITS];
    logic [3:0]           digits_d [MAX_DIGITS];
    logic [c_CNT_W-1:0]   cnt_q, cnt_d;
    logic [c_CNT_W-1:0]   idx_q, idx_d;
    logic [c_ACC_W-1:0]   acc_q, acc_d;
    logic [15:0]          value_q, value_d;
    logic                 vv_q, vv_d;
    logic                 ovf_q, ovf_d;
    logic                 drop_q, drop_d;

    logic                      w_echo_load;
    logic [1:0]                w_echo_cnt;
    logic [8*c_ECHO_DEPTH-1:0] w_echo_data;
    logic                      w_echo_idle;
    logic [3:0]                w_cur_digit;
    logic [c_ACC_W-1:0]        w_acc_next;

    line_echo_tx u_echo (
        .clk         (clk),
        .rst         (rst),
        .load_i      (w_echo_load),
        .load_cnt_i  (w_echo_cnt),
        .load_data_i (w_echo_data),
        .tx_busy_i   (bus.tx_busy),
        .tx_req_o    (bus.tx_req),
        .tx_data_o   (bus.tx_data),
        .echo_idle_o (w_echo_idle)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            value_q <= '0;
            vv_q    <= 1'b0;
            ovf_q   <= 1'b0;
            drop_q  <= 1'b0;
            for (int i = 0; i < MAX_DIGITS; i++) begin
                digits_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            digits_q <= digits_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            value_q  <= value_d;
            vv_q     <= vv_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    // Oldest digit sits at index 0, so walking idx upward is MSB-first.
    always_comb begin
        w_cur_digit = 4'd0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (c_CNT_W'(i) == idx_q) begin
                w_cur_digit = digits_q[i];
            end
        end
        w_acc_next = (acc_q * c_ACC_W'(10)) + c_ACC_W'(w_cur_digit);
    end

    always_comb begin
        state_d     = state_q;
        digits_d    = digits_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        value_d     = value_q;
        vv_d        = 1'b0;
        ovf_d       = ovf_q;
        drop_d      = drop_q;
        w_echo_load = 1'b0;
        w_echo_cnt  = 2'd1;
        w_echo_data = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    for (int i = 0; i < MAX_DIGITS; i++) begin
                        digits_d[i] = '0;
                    end
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    drop_d  = 1'b0;
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (bus.rx_valid) begin
                    if (is_digit(bus.rx_byte)) begin
                        if (cnt_q < c_CNT_W'(MAX_DIGITS)) begin
                            for (int i = 0; i < MAX_DIGITS; i++) begin
                                if (c_CNT_W'(i) == cnt_q) begin
                                    digits_d[i] = bus.rx_byte[3:0];
                                end
                            end
                            cnt_d            = cnt_q + c_CNT_W'(1);
                            w_echo_load      = 1'b1;
                            w_echo_data[7:0] = bus.rx_byte;
                            state_d          = ST_ECHO;
                        end
                    end else if (bus.rx_byte == c_ASCII_CR) begin
                        acc_d = '0;
                        idx_d = '0;
                        if (cnt_q == '0) begin
                            value_d = 16'h0000;
                            ovf_d   = 1'b0;
                            vv_d    = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_CONVERT;
                        end
                    end
`ifdef LINE_BACKSPACE_EN
                    else if (((bus.rx_byte == c_ASCII_BS) || (bus.rx_byte == c_ASCII_DEL))
                             && (cnt_q != '0)) begin
                        cnt_d       = cnt_q - c_CNT_W'(1);
                        w_echo_load = 1'b1;
                        w_echo_cnt  = 2'd3;
                        w_echo_data = {c_ASCII_BS, c_ASCII_SP, c_ASCII_BS};
                        state_d     = ST_ECHO;
                    end
`endif
                end
            end
            ST_ECHO: begin
                if (bus.rx_valid) begin
                    drop_d = 1'b1;
                end
                if (w_echo_idle) begin
                    state_d = ST_COLLECT;
                end
            end
            ST_CONVERT: begin
                if (bus.rx_valid) begin
                    drop_d = 1'b1;
                end
                acc_d = w_acc_next;
                idx_d = idx_q + c_CNT_W'(1);
                if (idx_q == (cnt_q - c_CNT_W'(1))) begin
                    {ovf_d, value_d} = saturate16(w_acc_next);
                    vv_d             = 1'b1;
                    state_d          = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.rx_valid) begin
                    drop_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.value       = value_q;
    assign bus.value_valid = vv_q;
    assign bus.overflow    = ovf_q;
    assign bus.rx_dropped  = drop_q;

endmodule

`default_nettype wire

// File: doc/uart_dec_line_reader.md
# uart_dec_line_reader

Receive-side line parser for the UART console. Sits between the `uart` receiver outputs (`received`, `rx_byte`) and the top-level FSM. On `start` it collects ASCII decimal digits, echoes each accepted character through the `uart` transmit handshake, and on carriage return converts the buffered digits to a saturated 16-bit binary value. It returns that value with a one-cycle valid pulse; this is the input counterpart of the top level's string-print path.

## Interface
- `MAX_DIGITS`, 5: digit buffer depth (1..5).
- `clk`  in  1  system clock (100 MHz).
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  arm a new line read; honoured only in IDLE.
- `rx_valid`  in  1  one-cycle strobe from `uart.received`.
- `rx_byte`  in  8  received byte, valid with `rx_valid`.
- `tx_busy`  in  1  `uart.is_transmitting`.
- `tx_req`  out  1  transmit request to `uart.transmit`.
- `tx_data`  out  8  echo byte to `uart.tx_byte`, stable while `tx_req` or echo in flight.
- `busy`  out  1  high in every state except IDLE.
- `value`  out  16  converted result, held until next `start`.
- `value_valid`  out  1  one-cycle pulse when `value` is updated.
- `overflow`  out  1  result saturated; held with `value`.
- `rx_dropped`  out  1  sticky: a byte arrived while not in COLLECT with `busy` high; cleared on `start`.

## Operation
- States: IDLE, COLLECT, ECHO_REQ, ECHO_WAIT_START, ECHO_WAIT_END, CONVERT, DONE.
- IDLE:
  - `start` clears the digit buffer, `digit_cnt`, `overflow` and `rx_dropped`.
  - Next state is COLLECT.
  - `rx_valid` in IDLE is ignored and does not set `rx_dropped`.
- COLLECT, on `rx_valid`:
  - '0'..'9' (0x30..0x39) with `digit_cnt < MAX_DIGITS`: push digit (byte − 0x30) and queue an echo of that byte.
  - Digit when the buffer is full: ignored, no echo.
  - 0x0D: go to CONVERT. 0x0D is not echoed.
  - Any other byte, including 0x0A: ignored.
- Echo sequence:
  - ECHO_REQ drives `tx_req=1` while `tx_busy=0`, then moves to ECHO_WAIT_START.
  - ECHO_WAIT_START waits for `tx_busy=1`. ECHO_WAIT_END waits for `tx_busy=0`.
  - Then the next queued echo byte (back to ECHO_REQ), or COLLECT.
- CONVERT:
  - Uses a 20-bit accumulator, cleared on entry.
  - Each cycle: `acc = acc*10 + digit[i]`, for `i = 0..digit_cnt−1`, oldest digit first.
  - Then go to DONE.
- DONE:
  - If `acc > 65535`: `value = 16'hFFFF`, `overflow = 1`. Otherwise `value = acc[15:0]`.
  - `value_valid = 1` for this cycle only, then IDLE.
- Boundaries:
  - Enter with zero digits gives `value = 0` and `overflow = 0`.
  - `start` outside IDLE is ignored.
  - Any `rx_valid` in ECHO_* or CONVERT sets `rx_dropped`; the byte is lost.

## Timing
- Reset values: state IDLE; `tx_req`, `busy`, `value_valid`, `overflow` and `rx_dropped` all 0; `value` 0; `tx_data` 0; `digit_cnt` 0.
- `start` at cycle t: `busy` is 1 from t+1.
- Echo of a digit arriving at t: `tx_req` is first possible at t+1. `tx_req` is a registered output held high until the cycle in which `tx_busy` is sampled low with the request issued.
- 0x0D at t with N digits buffered:
  - CONVERT occupies t+1 .. t+N.
  - DONE and `value_valid` fall at t+1+N, so N=0 gives t+1.
  - IDLE is reached at t+2+N.
- `rst` mid-operation: everything returns to reset values on the next edge, and any queued echo is discarded. A byte already inside `uart` completes on the line.

## Configuration
- `LINE_BACKSPACE_EN` defined:
  - 0x08 or 0x7F in COLLECT with `digit_cnt > 0` pops the newest digit.
  - It queues a three-byte echo 0x08, 0x20, 0x08 through the echo sequence.
  - With `digit_cnt = 0` the byte is ignored and nothing is echoed.
- `LINE_BACKSPACE_EN` undefined: 0x08 and 0x7F are treated as other bytes and ignored; the echo queue depth is 1.

## Structure
- Package `line_reader_pkg`: state encoding, ASCII constants (CR 0x0D, LF 0x0A, BS 0x08, DEL 0x7F, SP 0x20, '0' 0x30), `MAX_DIGITS` default, accumulator width 20.
- Sub-module `line_echo_tx`:
  - Holds the echo queue (depth 3 or 1) and the ECHO_REQ / WAIT_START / WAIT_END handshake against `tx_busy`.
  - Reports `echo_idle` to the parent.
  - The parent holds COLLECT, CONVERT and DONE.

## Test plan
- Start, send "1","2","3",0x0D → echoes 0x31, 0x32, 0x33 in order, each on a distinct `tx_req`; `value = 123`, `overflow = 0`; `value_valid` is 4 cycles after CR.
- Start, send "99999",0x0D → `value = 16'hFFFF`, `overflow = 1`; send "65535",CR → 0xFFFF, `overflow = 0`.
- Start, send "123456",CR → the sixth digit is not echoed; `value = 12345`.
- Start, send CR immediately → `value = 0`, `value_valid` at t+1; send "a",0x0A,"7",CR → `value = 7`, only "7" echoed.
- With `LINE_BACKSPACE_EN`, send "4","5",0x08,"6",CR → echo 34 35 08 20 08 36; `value = 46`. A second "8" sent during the 3-byte echo sets `rx_dropped`.
- Assert `rst` during ECHO_WAIT_END after "9" → next cycle IDLE, `tx_req = 0`, `busy = 0`; a fresh start with "8",CR → `value = 8`.
